// File: rtl/matmul_sequencer_if.sv
// rtl/matmul_sequencer_if.sv - handshake and memory/MAC control bundle of the 8x8 matmul sequencer
//
// Signals (direction as seen from the sequencer, modport master):
//   start       in   begin a multiply, honoured only while the sequencer is idle
//   busy        out  run in progress (cycle 0 up to, not including, the done cycle)
//   done        out  one-cycle pulse after the final C write
//   rd_en       out  A/B read strobe
//   a_addr      out  A element address, row*N + k
//   b_addr      out  B row address k (one B word carries all N columns)
//   mac_en      out  MAC lanes accumulate this cycle
//   mac_clear   out  with mac_en, lanes load the product instead of accumulating
//   buf_load    out  row buffer captures all lane outputs at the end of this cycle
//   out_sel     out  buffer lane steered onto the C write data
//   c_we        out  C memory write enable
//   c_addr      out  C address, row*N + out_sel
//   clock_count out  cycles since start was accepted, saturating
// The slave modport is the mirror image, for the datapath / host side.
interface matmul_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int K_W    = 3,
  parameter int CNT_W  = 11
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] a_addr;
  logic [K_W-1:0]    b_addr;
  logic              mac_en;
  logic              mac_clear;
  logic              buf_load;
  logic [K_W-1:0]    out_sel;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [CNT_W-1:0]  clock_count;

  modport master (
    input  start,
    output busy, done, rd_en, a_addr, b_addr, mac_en, mac_clear,
           buf_load, out_sel, c_we, c_addr, clock_count
  );

  modport slave (
    output start,
    input  busy, done, rd_en, a_addr, b_addr, mac_en, mac_clear,
           buf_load, out_sel, c_we, c_addr, clock_count
  );
endinterface

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - controller sequencing reads, MAC lanes, row buffer and C writes for C = A x B
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high; aborts any run immediately
//   bus    matmul_sequencer_if.master (start/busy/done handshake, A/B read
//          addresses, MAC enable/clear, buffer load, C write port, cycle count)
//
// Row r is issued on cycles 8r..8r+7; its products land in the MACs RD_LAT
// cycles later and the buffer captures the finished row one cycle after
// that. Draining a row (N writes) overlaps issuing the next one, so C is
// written once per cycle without gaps. RD_LAT must be 1..3.
module matmul_sequencer #(
  parameter int N      = 8,
  parameter int ADDR_W = 6,
  parameter int K_W    = 3,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 11
) (
  input  logic               clk,
  input  logic               reset,
  matmul_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N*N - 1);
  localparam logic [K_W-1:0]    LAST_K   = K_W'(N - 1);

  state_t            state;
  // Read-latency delay chains; bit 0 is the newest stage.
  logic [RD_LAT-1:0] en_sr;
  logic [RD_LAT-1:0] clr_sr;
  logic [RD_LAT-1:0] last_sr;
  // Index of the next C element to write; runs 0..N*N-1 across all rows.
  logic [ADDR_W-1:0] wr_idx;
  logic              drain_go;

  assign bus.mac_en    = en_sr[RD_LAT-1];
  assign bus.mac_clear = clr_sr[RD_LAT-1];

  // Keep writing while a fresh row was just captured, or while the current
  // row still has lanes left. A capture on the last lane of the previous
  // row chains straight into the next row.
  assign drain_go = bus.buf_load || (bus.c_we && (bus.out_sel != LAST_K));

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      en_sr           <= '0;
      clr_sr          <= '0;
      last_sr         <= '0;
      wr_idx          <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.rd_en       <= 1'b0;
      bus.a_addr      <= '0;
      bus.b_addr      <= '0;
      bus.buf_load    <= 1'b0;
      bus.out_sel     <= '0;
      bus.c_we        <= 1'b0;
      bus.c_addr      <= '0;
      bus.clock_count <= '0;
    end else begin
      // Chains shift every cycle, including through FLUSH, so the tail of
      // the last row still reaches the MACs and the buffer.
      en_sr   <= RD_LAT'({en_sr, bus.rd_en});
      clr_sr  <= RD_LAT'({clr_sr, bus.rd_en && (bus.b_addr == '0)});
      last_sr <= RD_LAT'({last_sr, bus.rd_en && (bus.b_addr == LAST_K)});
      // One extra stage: capture after the k=N-1 product is in the MACs.
      bus.buf_load <= last_sr[RD_LAT-1];

      if (drain_go) begin
        bus.c_we    <= 1'b1;
        bus.c_addr  <= wr_idx;
        bus.out_sel <= wr_idx[K_W-1:0];
        wr_idx      <= wr_idx + 1'b1;
      end else begin
        bus.c_we <= 1'b0;
      end

      if ((state != IDLE) && (bus.clock_count != '1)) begin
        bus.clock_count <= bus.clock_count + 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state           <= RUN;
            bus.busy        <= 1'b1;
            bus.clock_count <= '0;
            bus.rd_en       <= 1'b1;
            bus.a_addr      <= '0;
            bus.b_addr      <= '0;
            wr_idx          <= '0;
          end
        end
        RUN: begin
          if (bus.a_addr == LAST_IDX) begin
            bus.rd_en <= 1'b0;
            state     <= FLUSH;
          end else begin
            bus.a_addr <= bus.a_addr + 1'b1;
            bus.b_addr <= bus.b_addr + 1'b1;
          end
        end
        FLUSH: begin
          if (bus.c_we && (bus.c_addr == LAST_IDX)) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - directed self-checking bench for matmul_sequencer at RD_LAT 1 and 3
module tb_matmul_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  bit   clr_mem = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  logic [7:0] a_mem [64];
  logic [7:0] b_mem [8][8];

  always #5 clk = ~clk;

  // lane[0]: RD_LAT=1, lane[1]: RD_LAT=3, both driven by the same start/reset.
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    matmul_sequencer_if #(.ADDR_W(6), .K_W(3), .CNT_W(11)) bus ();
    assign bus.start = start;

    matmul_sequencer #(
      .N(8), .ADDR_W(6), .K_W(3), .RD_LAT(LAT), .CNT_W(11)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    // Datapath model: memories with LAT read latency, 8 MAC lanes,
    // row buffer and C memory, all steered only by the DUT controls.
    logic [7:0]  a_pipe [LAT];
    logic [7:0]  b_pipe [LAT][8];
    logic [18:0] acc  [8];
    logic [18:0] rbuf [8];
    logic [18:0] cmem [64];
    int          wr_cnt;

    always @(posedge clk) begin
      if (clr_mem) begin
        for (int i = 0; i < 64; i++) cmem[i] = '1;
        wr_cnt = 0;
      end
      if (bus.c_we) begin
        cmem[bus.c_addr] = rbuf[bus.out_sel];
        wr_cnt++;
      end
      if (bus.buf_load)
        for (int j = 0; j < 8; j++) rbuf[j] = acc[j];
      if (bus.mac_en)
        for (int j = 0; j < 8; j++)
          acc[j] = (bus.mac_clear ? 19'd0 : acc[j]) +
                   19'(a_pipe[LAT-1]) * 19'(b_pipe[LAT-1][j]);
      for (int s = LAT - 1; s > 0; s--) begin
        a_pipe[s] = a_pipe[s-1];
        for (int j = 0; j < 8; j++) b_pipe[s][j] = b_pipe[s-1][j];
      end
      if (bus.rd_en) begin
        a_pipe[0] = a_mem[bus.a_addr];
        for (int j = 0; j < 8; j++) b_pipe[0][j] = b_mem[bus.b_addr][j];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected outputs at cycle t of a run, from the documented timeline.
  task automatic check_state(input string id, input int L, input int t,
                             input logic busy, input logic done, input logic rd_en,
                             input logic [5:0] a_addr, input logic [2:0] b_addr,
                             input logic mac_en, input logic mac_clear,
                             input logic buf_load, input logic c_we,
                             input logic [5:0] c_addr, input logic [2:0] out_sel,
                             input logic [10:0] cc);
    logic e_mac;
    e_mac = (t >= L) && (t < 64 + L);
    chk({id, "_busy"}, busy, t <= 72 + L);
    chk({id, "_done"}, done, t == 73 + L);
    chk({id, "_rd_en"}, rd_en, t < 64);
    chk({id, "_mac_en"}, mac_en, e_mac);
    chk({id, "_mac_clear"}, mac_clear, e_mac && ((t - L) % 8 == 0));
    chk({id, "_buf_load"}, buf_load,
        (t >= 8 + L) && (t <= 64 + L) && ((t - 8 - L) % 8 == 0));
    chk({id, "_c_we"}, c_we, (t >= 9 + L) && (t <= 72 + L));
    if (t < 64) begin
      chk({id, "_a_addr"}, a_addr, t);
      chk({id, "_b_addr"}, b_addr, t % 8);
    end
    if ((t >= 9 + L) && (t <= 72 + L)) begin
      chk({id, "_c_addr"}, c_addr, t - 9 - L);
      chk({id, "_out_sel"}, out_sel, (t - 9 - L) % 8);
    end
    if (t <= 73 + L) chk({id, "_clock_count"}, cc, t);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_L1"}, {lane[0].bus.busy, lane[0].bus.done, lane[0].bus.rd_en,
        lane[0].bus.a_addr, lane[0].bus.b_addr, lane[0].bus.mac_en,
        lane[0].bus.mac_clear, lane[0].bus.buf_load, lane[0].bus.out_sel,
        lane[0].bus.c_we, lane[0].bus.c_addr}, 0);
    chk({tag, "_L1_cc"}, lane[0].bus.clock_count, 0);
    chk({tag, "_L3"}, {lane[1].bus.busy, lane[1].bus.done, lane[1].bus.rd_en,
        lane[1].bus.a_addr, lane[1].bus.b_addr, lane[1].bus.mac_en,
        lane[1].bus.mac_clear, lane[1].bus.buf_load, lane[1].bus.out_sel,
        lane[1].bus.c_we, lane[1].bus.c_addr}, 0);
    chk({tag, "_L3_cc"}, lane[1].bus.clock_count, 0);
  endtask

  task automatic clear_c();
    clr_mem = 1'b1;
    @(negedge clk);
    clr_mem = 1'b0;
  endtask

  // hold=1 keeps start high through the run and the L1 DONE cycle.
  task automatic run(input bit hold);
    start = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= 86; t++) begin
      if (!hold || t == 75) start = 1'b0;
      check_state("L1", 1, t, lane[0].bus.busy, lane[0].bus.done, lane[0].bus.rd_en,
                  lane[0].bus.a_addr, lane[0].bus.b_addr, lane[0].bus.mac_en,
                  lane[0].bus.mac_clear, lane[0].bus.buf_load, lane[0].bus.c_we,
                  lane[0].bus.c_addr, lane[0].bus.out_sel, lane[0].bus.clock_count);
      check_state("L3", 3, t, lane[1].bus.busy, lane[1].bus.done, lane[1].bus.rd_en,
                  lane[1].bus.a_addr, lane[1].bus.b_addr, lane[1].bus.mac_en,
                  lane[1].bus.mac_clear, lane[1].bus.buf_load, lane[1].bus.c_we,
                  lane[1].bus.c_addr, lane[1].bus.out_sel, lane[1].bus.clock_count);
      @(negedge clk);
    end
  endtask

  task automatic check_c_equals_b(input string tag);
    for (int i = 0; i < 64; i++) begin
      chk({tag, "_L1"}, lane[0].cmem[i], i);
      chk({tag, "_L3"}, lane[1].cmem[i], i);
    end
    chk({tag, "_wrcnt_L1"}, lane[0].wr_cnt, 64);
    chk({tag, "_wrcnt_L3"}, lane[1].wr_cnt, 64);
  endtask

  initial begin
    // Identity A, B[i][j] = 8i + j, so C[i*8+j] = i*8+j.
    for (int i = 0; i < 64; i++) a_mem[i] = ((i / 8) == (i % 8)) ? 8'd1 : 8'd0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) b_mem[i][j] = 8'(8 * i + j);

    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("idle_after_reset");

    clear_c();
    run(1'b0);
    check_c_equals_b("c_identity");

    clear_c();
    run(1'b1);
    check_c_equals_b("c_hold_start");

    // Abort at cycle 30.
    clear_c();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("abort");
    reset = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      chk("post_abort_quiet", {lane[0].bus.c_we, lane[0].bus.done, lane[0].bus.busy,
          lane[1].bus.c_we, lane[1].bus.done, lane[1].bus.busy}, 0);
    end

    clear_c();
    run(1'b0);
    check_c_equals_b("c_after_abort");

    // All-max operands: each entry is 8 * 255 * 255 = 520200.
    for (int i = 0; i < 64; i++) a_mem[i] = 8'hFF;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) b_mem[i][j] = 8'hFF;
    clear_c();
    run(1'b0);
    for (int i = 0; i < 64; i++) begin
      chk("c_max_L1", lane[0].cmem[i], 32'd520200);
      chk("c_max_L3", lane[1].cmem[i], 32'd520200);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
